bank_biu_wb_ctrl: RTL and testbench

BANK_BIU_WB_CTRL -- requirements
Module: bank_biu_wb_ctrl

---
 rtl/bank_biu_pkg.sv | 17 +
 rtl/bank_biu_wb_buf.sv | 43 ++++
 rtl/bank_biu_wb_ctrl.sv | 178 +++++++++++++++++
 tb/tb_bank_biu_wb_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_biu_pkg.sv
// Shared types and AXI3 constants for the bank BIU writeback path.
package bank_biu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_ISSUE,
        ST_WAIT_B
    } wb_state_e;

    localparam logic [2:0] AXSIZE_32B    = 3'b101;
    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam int         HALF_WIDTH    = 128;
    localparam int         SET_WAY_WIDTH = 6;

endpackage

// File: rtl/bank_biu_wb_buf.sv
// Writeback line buffer: assembles a 256-bit line from two 128-bit SRAM halves
// in either order, tracking which halves have arrived.
module bank_biu_wb_buf
    import bank_biu_pkg::*;
(
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    clr,
    input  logic                    we,
    input  logic                    offset,
    input  logic [HALF_WIDTH-1:0]   data,
    output logic [2*HALF_WIDTH-1:0] line,
    output logic [1:0]              vld
);

    logic [HALF_WIDTH-1:0] lo_q;
    logic [HALF_WIDTH-1:0] hi_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            vld <= 2'b00;
        end else if (clr) begin
            vld <= 2'b00;
        end else if (we) begin
            vld[offset] <= 1'b1;
        end
    end

    // NOTE: the data halves carry no reset; the valid bits alone say whether
    // they hold anything, so resetting 256 flops would buy nothing.
    always_ff @(posedge clk_i) begin
        if (we) begin
            if (offset) begin
                hi_q <= data;
            end else begin
                lo_q <= data;
            end
        end
    end

    assign line = {hi_q, lo_q};

endmodule

// File: rtl/bank_biu_wb_ctrl.sv
// Bank BIU writeback controller: takes a victim line from the SRAM in two halves
// and writes it out as a single-beat AXI3 burst. Optional BRESP error flag via
// BANK_BIU_WB_BRESP_CHK_EN.
module bank_biu_wb_ctrl
    import bank_biu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    htu_biu_awvalid_i,
    output logic                    htu_biu_awready_o,
    input  logic [ADDR_WIDTH-6:0]   htu_biu_awaddr_i,
    input  logic [5:0]              htu_biu_set_way_i,

    input  logic                    sc_biu_valid_i,
    output logic                    sc_biu_ready_o,
    input  logic [127:0]            sc_biu_data_i,
    input  logic                    sc_biu_offset_i,

    output logic                    biu_axi3_awvalid_o,
    input  logic                    biu_axi3_awready_i,
    output logic [ID_WIDTH-1:0]     biu_axi3_awid_o,
    output logic [ADDR_WIDTH-1:0]   biu_axi3_awaddr_o,
    output logic [3:0]              biu_axi3_awlen_o,
    output logic [2:0]              biu_axi3_awsize_o,
    output logic [1:0]              biu_axi3_awburst_o,

    output logic                    biu_axi3_wvalid_o,
    input  logic                    biu_axi3_wready_i,
    output logic [ID_WIDTH-1:0]     biu_axi3_wid_o,
    output logic [DATA_WIDTH-1:0]   biu_axi3_wdata_o,
    output logic [DATA_WIDTH/8-1:0] biu_axi3_wstrb_o,
    output logic                    biu_axi3_wlast_o,

    input  logic                    biu_axi3_bvalid_i,
    output logic                    biu_axi3_bready_o,
    input  logic [ID_WIDTH-1:0]     biu_axi3_bid_i,
    input  logic [1:0]              biu_axi3_bresp_i,

    output logic                    wb_busy_o,
    output logic                    wb_done_o,
    output logic                    wb_err_o
);

    wb_state_e                  state_q;
    wb_state_e                  state_d;
    logic [ADDR_WIDTH-6:0]      line_q;
    logic [SET_WAY_WIDTH-1:0]   set_way_q;
    logic                       aw_done_q;
    logic                       w_done_q;
    logic [ID_WIDTH-1:0]        wb_id;
    logic [2*HALF_WIDTH-1:0]    buf_line;
    logic [1:0]                 buf_vld;
    logic [1:0]                 beat_mask;
    logic                       req_fire;
    logic                       sc_fire;
    logic                       aw_fire;
    logic                       w_fire;
    logic                       b_match;

    assign req_fire  = htu_biu_awvalid_i && htu_biu_awready_o;
    assign sc_fire   = sc_biu_valid_i && sc_biu_ready_o;
    assign aw_fire   = biu_axi3_awvalid_o && biu_axi3_awready_i;
    assign w_fire    = biu_axi3_wvalid_o && biu_axi3_wready_i;
    assign wb_id     = {{(ID_WIDTH-SET_WAY_WIDTH){1'b0}}, set_way_q};
    assign b_match   = biu_axi3_bvalid_i && (biu_axi3_bid_i == wb_id);
    assign beat_mask = sc_fire ? (2'b01 << sc_biu_offset_i) : 2'b00;

    bank_biu_wb_buf u_buf (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    (req_fire),
        .we     (sc_fire),
        .offset (sc_biu_offset_i),
        .data   (sc_biu_data_i),
        .line   (buf_line),
        .vld    (buf_vld)
    );

    // NOTE: every clocked process updates state with <= so all flops sample the
    // same pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (req_fire) state_d = ST_FILL;
            ST_FILL:   if (&(buf_vld | beat_mask)) state_d = ST_ISSUE;
            ST_ISSUE:  if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = ST_WAIT_B;
            ST_WAIT_B: if (b_match) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        htu_biu_awready_o  = 1'b0;
        sc_biu_ready_o     = 1'b0;
        biu_axi3_awvalid_o = 1'b0;
        biu_axi3_wvalid_o  = 1'b0;
        biu_axi3_bready_o  = 1'b0;
        wb_done_o          = 1'b0;
        unique case (state_q)
            ST_IDLE:   htu_biu_awready_o = 1'b1;
            ST_FILL:   sc_biu_ready_o    = 1'b1;
            ST_ISSUE: begin
                biu_axi3_awvalid_o = !aw_done_q;
                biu_axi3_wvalid_o  = !w_done_q;
            end
            ST_WAIT_B: begin
                biu_axi3_bready_o = 1'b1;
                wb_done_o         = b_match;
            end
        endcase
    end

    // AW and W retire independently; these remember which one already has.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q != ST_ISSUE) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_fire) aw_done_q <= 1'b1;
            if (w_fire)  w_done_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            line_q    <= htu_biu_awaddr_i;
            set_way_q <= htu_biu_set_way_i;
        end
    end

    assign wb_busy_o          = (state_q != ST_IDLE);
    assign biu_axi3_awaddr_o  = {line_q, 5'b0};
    assign biu_axi3_awid_o    = wb_id;
    assign biu_axi3_awlen_o   = 4'd0;
    assign biu_axi3_awsize_o  = AXSIZE_32B;
    assign biu_axi3_awburst_o = BURST_INCR;
    assign biu_axi3_wid_o     = wb_id;
    assign biu_axi3_wdata_o   = DATA_WIDTH'(buf_line);
    assign biu_axi3_wstrb_o   = '1;
    assign biu_axi3_wlast_o   = 1'b1;

`ifdef BANK_BIU_WB_BRESP_CHK_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            err_q <= 1'b0;
        end else if (wb_done_o && (biu_axi3_bresp_i != RESP_OKAY)) begin
            err_q <= 1'b1;
        end
    end

    assign wb_err_o = err_q;
`else
    logic unused_bresp;

    assign unused_bresp = ^biu_axi3_bresp_i;
    assign wb_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_bank_biu_wb_ctrl.sv
// Directed, table-driven bench for bank_biu_wb_ctrl (works with or without
// BANK_BIU_WB_BRESP_CHK_EN).
module tb_bank_biu_wb_ctrl;

    localparam logic [127:0] D0   = 128'h00112233_44556677_8899aabb_ccddeeff;
    localparam logic [127:0] D1   = 128'hfedcba98_76543210_0f1e2d3c_4b5a6978;
    localparam logic [127:0] D2   = 128'hdeadbeef_cafef00d_01234567_89abcdef;
    localparam logic [127:0] D3   = 128'h5a5a5a5a_a5a5a5a5_3c3c3c3c_c3c3c3c3;
    localparam logic [127:0] D4   = 128'h11111111_22222222_33333333_44444444;
    localparam logic [127:0] JUNK = 128'hbad0bad0_bad0bad0_bad0bad0_bad0bad0;

    typedef struct {
        logic [26:0]        line;
        logic [5:0]         sw;
        int                 nbeats;
        logic [2:0]         off;
        logic [2:0][127:0]  dat;
        int                 aw_stall;
        int                 w_stall;
        bit                 junk;
        bit                 send_bad;
        logic [7:0]         bad_bid;
        logic [1:0]         bresp;
        logic [31:0]        exp_addr;
        logic [7:0]         exp_id;
        logic [255:0]       exp_wdata;
    } vec_t;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         htu_biu_awvalid_i;
    logic         htu_biu_awready_o;
    logic [26:0]  htu_biu_awaddr_i;
    logic [5:0]   htu_biu_set_way_i;
    logic         sc_biu_valid_i;
    logic         sc_biu_ready_o;
    logic [127:0] sc_biu_data_i;
    logic         sc_biu_offset_i;
    logic         biu_axi3_awvalid_o;
    logic         biu_axi3_awready_i;
    logic [7:0]   biu_axi3_awid_o;
    logic [31:0]  biu_axi3_awaddr_o;
    logic [3:0]   biu_axi3_awlen_o;
    logic [2:0]   biu_axi3_awsize_o;
    logic [1:0]   biu_axi3_awburst_o;
    logic         biu_axi3_wvalid_o;
    logic         biu_axi3_wready_i;
    logic [7:0]   biu_axi3_wid_o;
    logic [255:0] biu_axi3_wdata_o;
    logic [31:0]  biu_axi3_wstrb_o;
    logic         biu_axi3_wlast_o;
    logic         biu_axi3_bvalid_i;
    logic         biu_axi3_bready_o;
    logic [7:0]   biu_axi3_bid_i;
    logic [1:0]   biu_axi3_bresp_i;
    logic         wb_busy_o;
    logic         wb_done_o;
    logic         wb_err_o;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    logic err_model = 1'b0;
    vec_t vecs[8];

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) if (wb_done_o) done_cnt <= done_cnt + 1;

    bank_biu_wb_ctrl dut (
        .clk_i              (clk_i),
        .rst_i              (rst_i),
        .htu_biu_awvalid_i  (htu_biu_awvalid_i),
        .htu_biu_awready_o  (htu_biu_awready_o),
        .htu_biu_awaddr_i   (htu_biu_awaddr_i),
        .htu_biu_set_way_i  (htu_biu_set_way_i),
        .sc_biu_valid_i     (sc_biu_valid_i),
        .sc_biu_ready_o     (sc_biu_ready_o),
        .sc_biu_data_i      (sc_biu_data_i),
        .sc_biu_offset_i    (sc_biu_offset_i),
        .biu_axi3_awvalid_o (biu_axi3_awvalid_o),
        .biu_axi3_awready_i (biu_axi3_awready_i),
        .biu_axi3_awid_o    (biu_axi3_awid_o),
        .biu_axi3_awaddr_o  (biu_axi3_awaddr_o),
        .biu_axi3_awlen_o   (biu_axi3_awlen_o),
        .biu_axi3_awsize_o  (biu_axi3_awsize_o),
        .biu_axi3_awburst_o (biu_axi3_awburst_o),
        .biu_axi3_wvalid_o  (biu_axi3_wvalid_o),
        .biu_axi3_wready_i  (biu_axi3_wready_i),
        .biu_axi3_wid_o     (biu_axi3_wid_o),
        .biu_axi3_wdata_o   (biu_axi3_wdata_o),
        .biu_axi3_wstrb_o   (biu_axi3_wstrb_o),
        .biu_axi3_wlast_o   (biu_axi3_wlast_o),
        .biu_axi3_bvalid_i  (biu_axi3_bvalid_i),
        .biu_axi3_bready_o  (biu_axi3_bready_o),
        .biu_axi3_bid_i     (biu_axi3_bid_i),
        .biu_axi3_bresp_i   (biu_axi3_bresp_i),
        .wb_busy_o          (wb_busy_o),
        .wb_done_o          (wb_done_o),
        .wb_err_o           (wb_err_o)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [26:0] line, input logic [5:0] sw, input int nbeats,
                                input logic [2:0] off, input logic [127:0] d0, input logic [127:0] d1,
                                input logic [127:0] d2, input int aw_stall, input int w_stall,
                                input bit junk, input bit send_bad, input logic [7:0] bad_bid,
                                input logic [1:0] bresp, input logic [31:0] exp_addr,
                                input logic [7:0] exp_id, input logic [255:0] exp_wdata);
        vec_t v;
        v.line = line;           v.sw = sw;             v.nbeats = nbeats;
        v.off = off;             v.dat[0] = d0;         v.dat[1] = d1;
        v.dat[2] = d2;           v.aw_stall = aw_stall; v.w_stall = w_stall;
        v.junk = junk;           v.send_bad = send_bad; v.bad_bid = bad_bid;
        v.bresp = bresp;         v.exp_addr = exp_addr; v.exp_id = exp_id;
        v.exp_wdata = exp_wdata;
        return v;
    endfunction

    task automatic idle_inputs();
        htu_biu_awvalid_i  = 1'b0;
        htu_biu_awaddr_i   = '0;
        htu_biu_set_way_i  = '0;
        sc_biu_valid_i     = 1'b0;
        sc_biu_data_i      = '0;
        sc_biu_offset_i    = 1'b0;
        biu_axi3_awready_i = 1'b0;
        biu_axi3_wready_i  = 1'b0;
        biu_axi3_bvalid_i  = 1'b0;
        biu_axi3_bid_i     = '0;
        biu_axi3_bresp_i   = 2'b00;
    endtask

    // Request + fill; leaves the DUT in its first ISSUE cycle with payload checked.
    task automatic req_and_fill(input vec_t v);
        @(negedge clk_i);
        htu_biu_awvalid_i = 1'b1;
        htu_biu_awaddr_i  = v.line;
        htu_biu_set_way_i = v.sw;
        #1;
        check("req_awready", htu_biu_awready_o, 1'b1);
        check("req_not_busy", wb_busy_o, 1'b0);
        for (int i = 0; i < v.nbeats; i++) begin
            @(negedge clk_i);
            htu_biu_awvalid_i = 1'b0;
            sc_biu_valid_i    = 1'b1;
            sc_biu_offset_i   = v.off[i];
            sc_biu_data_i     = v.dat[i];
            #1;
            check("fill_sc_ready", sc_biu_ready_o, 1'b1);
            check("fill_no_awvalid", biu_axi3_awvalid_o, 1'b0);
            check("fill_busy", wb_busy_o, 1'b1);
        end
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;
        #1;
        check("issue_awvalid", biu_axi3_awvalid_o, 1'b1);
        check("issue_wvalid", biu_axi3_wvalid_o, 1'b1);
        check("issue_sc_ready", sc_biu_ready_o, 1'b0);
        check("awaddr", biu_axi3_awaddr_o, v.exp_addr);
        check("awid", biu_axi3_awid_o, v.exp_id);
        check("wid", biu_axi3_wid_o, v.exp_id);
        check("wdata", biu_axi3_wdata_o, v.exp_wdata);
        check("awlen", biu_axi3_awlen_o, 4'd0);
        check("awsize", biu_axi3_awsize_o, 3'b101);
        check("awburst", biu_axi3_awburst_o, 2'b01);
        check("wstrb", biu_axi3_wstrb_o, 32'hffff_ffff);
        check("wlast", biu_axi3_wlast_o, 1'b1);
    endtask

    task automatic run_vec(input vec_t v);
        bit aw_seen = 0;
        bit w_seen  = 0;
        int k = 0;
        int done_start = done_cnt;
        req_and_fill(v);
        while (!(aw_seen && w_seen) && k < 50) begin
            @(negedge clk_i);
            biu_axi3_awready_i = (k >= v.aw_stall);
            biu_axi3_wready_i  = (k >= v.w_stall);
            sc_biu_valid_i     = v.junk;
            sc_biu_offset_i    = 1'b0;
            sc_biu_data_i      = JUNK;
            #1;
            check("issue_busy", wb_busy_o, 1'b1);
            if (v.junk) check("junk_sc_ready", sc_biu_ready_o, 1'b0);
            check("aw_hold", biu_axi3_awvalid_o, !aw_seen);
            check("w_hold", biu_axi3_wvalid_o, !w_seen);
            if (!aw_seen) check("awaddr_stable", biu_axi3_awaddr_o, v.exp_addr);
            if (!w_seen) check("wdata_stable", biu_axi3_wdata_o, v.exp_wdata);
            if (biu_axi3_awvalid_o && biu_axi3_awready_i) aw_seen = 1;
            if (biu_axi3_wvalid_o && biu_axi3_wready_i) w_seen = 1;
            k++;
        end
        if (!(aw_seen && w_seen)) check("issue_timeout", 1'b0, 1'b1);
        @(negedge clk_i);
        biu_axi3_awready_i = 1'b0;
        biu_axi3_wready_i  = 1'b0;
        sc_biu_valid_i     = 1'b0;
        #1;
        check("waitb_awvalid", biu_axi3_awvalid_o, 1'b0);
        check("waitb_wvalid", biu_axi3_wvalid_o, 1'b0);
        check("waitb_bready", biu_axi3_bready_o, 1'b1);
        if (v.send_bad) begin
            biu_axi3_bvalid_i = 1'b1;
            biu_axi3_bid_i    = v.bad_bid;
            biu_axi3_bresp_i  = 2'b00;
            #1;
            check("bad_bid_no_done", wb_done_o, 1'b0);
            @(negedge clk_i);
            #1;
            check("bad_bid_still_waiting", biu_axi3_bready_o, 1'b1);
        end
        biu_axi3_bvalid_i = 1'b1;
        biu_axi3_bid_i    = v.exp_id;
        biu_axi3_bresp_i  = v.bresp;
        #1;
        check("b_done_pulse", wb_done_o, 1'b1);
`ifdef BANK_BIU_WB_BRESP_CHK_EN
        if (v.bresp != 2'b00) err_model = 1'b1;
`endif
        @(negedge clk_i);
        biu_axi3_bvalid_i = 1'b0;
        biu_axi3_bresp_i  = 2'b00;
        #1;
        check("post_done_low", wb_done_o, 1'b0);
        check("post_idle_busy", wb_busy_o, 1'b0);
        check("post_awready", htu_biu_awready_o, 1'b1);
        check("done_count", done_cnt - done_start, 1);
        check("wb_err", wb_err_o, err_model);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_awready"}, htu_biu_awready_o, 1'b1);
        check({tag, "_busy"}, wb_busy_o, 1'b0);
        check({tag, "_awvalid"}, biu_axi3_awvalid_o, 1'b0);
        check({tag, "_wvalid"}, biu_axi3_wvalid_o, 1'b0);
        check({tag, "_bready"}, biu_axi3_bready_o, 1'b0);
        check({tag, "_sc_ready"}, sc_biu_ready_o, 1'b0);
        check({tag, "_done"}, wb_done_o, 1'b0);
        check({tag, "_err"}, wb_err_o, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int done_before;
        vecs[0] = mk(27'h091A2B7, 6'h2A, 2, 3'b010, D0, D1, '0, 0, 0, 0, 0, 8'h00, 2'b00,
                     32'h1234_56E0, 8'h2A, {D1, D0});
        vecs[1] = mk(27'h7FFFFFF, 6'h15, 2, 3'b001, D2, D3, '0, 0, 0, 0, 0, 8'h00, 2'b00,
                     32'hFFFF_FFE0, 8'h15, {D2, D3});
        vecs[2] = mk(27'h0000000, 6'h3F, 3, 3'b100, D0, D4, D2, 0, 0, 0, 0, 8'h00, 2'b00,
                     32'h0000_0000, 8'h3F, {D2, D4});
        vecs[3] = mk(27'h0000001, 6'h2A, 2, 3'b010, D3, D4, '0, 5, 0, 1, 0, 8'h00, 2'b00,
                     32'h0000_0020, 8'h2A, {D4, D3});
        vecs[4] = mk(27'h4000000, 6'h00, 2, 3'b001, D1, D0, '0, 0, 3, 0, 1, 8'h40, 2'b00,
                     32'h8000_0000, 8'h00, {D1, D0});
        vecs[5] = mk(27'h091A2B7, 6'h2A, 2, 3'b010, D0, D1, '0, 0, 0, 0, 1, 8'h01, 2'b00,
                     32'h1234_56E0, 8'h2A, {D1, D0});
        vecs[6] = mk(27'h0000ABC, 6'h01, 2, 3'b010, D0, D2, '0, 0, 0, 0, 0, 8'h00, 2'b10,
                     32'h0001_5780, 8'h01, {D2, D0});
        vecs[7] = mk(27'h0000001, 6'h22, 2, 3'b001, D3, D1, '0, 1, 1, 0, 0, 8'h00, 2'b00,
                     32'h0000_0020, 8'h22, {D3, D1});

        idle_inputs();
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        check_reset_outputs("reset");
        @(negedge clk_i);
        rst_i = 1'b1;

        // SRAM beat while IDLE must be refused.
        @(negedge clk_i);
        sc_biu_valid_i = 1'b1;
        sc_biu_data_i  = JUNK;
        #1;
        check("idle_sc_ready", sc_biu_ready_o, 1'b0);
        @(negedge clk_i);
        sc_biu_valid_i = 1'b0;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Reset in the middle of ISSUE abandons the write silently.
        done_before = done_cnt;
        req_and_fill(vecs[0]);
        #2;
        rst_i = 1'b0;
        #1;
        check_reset_outputs("midrst");
        err_model = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("midrst_no_done", done_cnt - done_before, 0);

        run_vec(vecs[1]);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
